// File: rtl/cnn_pkg.sv
`default_nettype none
// cnn_pkg: shared constants for the convolution / pooling pipeline.
package cnn_pkg;
   localparam int CONV_W      = 24;
   localparam int ACT_W       = 8;
   localparam int FMAP_W      = 8;
   localparam int FMAP_H      = 8;
   localparam int QUANT_SHIFT = 8;
endpackage
`default_nettype wire

// File: rtl/pool_line_buf.sv
`default_nettype none
// pool_line_buf: half-width row of horizontal partial maxima, one write port,
// asynchronous read at the same address.
module pool_line_buf
   import cnn_pkg::*;
#(
   parameter int DEPTH = FMAP_W / 2,
   parameter int W     = CONV_W,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [W-1:0]  i_wdata,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/relu_maxpool.sv
`default_nettype none
// relu_maxpool: ReLU + 2x2/stride-2 max-pool + shift/saturate quantiser on a
// raster-order conv_result stream, valid/ready on both sides.
module relu_maxpool
   import cnn_pkg::*;
#(
   parameter int IN_W  = CONV_W,
   parameter int OUT_W = ACT_W,
   parameter int IMG_W = FMAP_W,
   parameter int IMG_H = FMAP_H,
   parameter int SHIFT = QUANT_SHIFT
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   input  logic             out_ready,
   output logic             frame_done
);

   localparam int COL_W  = $clog2(IMG_W);
   localparam int ROW_W  = $clog2(IMG_H);
   localparam int NOUT   = (IMG_W / 2) * (IMG_H / 2);
   localparam int OCNT_W = (NOUT > 1) ? $clog2(NOUT) : 1;
   localparam int LB_D   = IMG_W / 2;
   localparam int LB_AW  = (LB_D > 1) ? $clog2(LB_D) : 1;
   localparam logic [IN_W-1:0] SAT_MAX = IN_W'((1 << OUT_W) - 1);

   logic [COL_W-1:0]  r_col;
   logic [ROW_W-1:0]  r_row;
   logic [OCNT_W-1:0] r_ocnt;
   logic [IN_W-1:0]   r_hmax;
   logic              r_out_valid;
   logic [OUT_W-1:0]  r_out_data;
   logic              r_frame_done;

   logic              w_acc;
   logic              w_oacc;
   logic              w_col_last;
   logic              w_row_last;
   logic              w_ocnt_last;
   logic              w_emit;
   logic              w_lb_we;
   logic [LB_AW-1:0]  w_lb_addr;
   logic [IN_W-1:0]   w_lb_rdata;
   logic [IN_W-1:0]   w_relu;
   logic [IN_W-1:0]   w_hmax_m;
   logic [IN_W-1:0]   w_pool;
   logic [IN_W-1:0]   w_q;
   logic [OUT_W-1:0]  w_sat;

   assign in_ready   = ~r_out_valid | out_ready;
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign frame_done = r_frame_done;

   // A clear in the same cycle drops the offered sample.
   assign w_acc       = in_valid & in_ready & ~clear;
   assign w_oacc      = r_out_valid & out_ready;
   assign w_col_last  = (r_col == COL_W'(IMG_W - 1));
   assign w_row_last  = (r_row == ROW_W'(IMG_H - 1));
   assign w_ocnt_last = (r_ocnt == OCNT_W'(NOUT - 1));

   assign w_relu   = in_data[IN_W-1] ? '0 : in_data;
   assign w_hmax_m = (w_relu > r_hmax) ? w_relu : r_hmax;
   assign w_pool   = (w_lb_rdata > w_hmax_m) ? w_lb_rdata : w_hmax_m;
   assign w_q      = w_pool >> SHIFT;
   assign w_sat    = (w_q > SAT_MAX) ? {OUT_W{1'b1}} : w_q[OUT_W-1:0];

   assign w_emit    = w_acc & r_col[0] & r_row[0];
   assign w_lb_we   = w_acc & r_col[0] & ~r_row[0];
   assign w_lb_addr = LB_AW'(r_col >> 1);

   pool_line_buf #(
      .DEPTH (LB_D),
      .W     (IN_W),
      .AW    (LB_AW)
   ) u_line_buf (
      .clk     (clk),
      .i_we    (w_lb_we),
      .i_addr  (w_lb_addr),
      .i_wdata (w_hmax_m),
      .o_rdata (w_lb_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_col <= '0;
         r_row <= '0;
      end else if (clear) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_acc) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
         end else begin
            r_col <= r_col + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hmax <= '0;
      end else if (w_acc && !r_col[0]) begin
         r_hmax <= w_relu;
      end
   end

   // A new result may overwrite one being accepted this cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (clear) begin
         r_out_valid <= 1'b0;
      end else if (w_emit) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_sat;
      end else if (w_oacc) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ocnt       <= '0;
         r_frame_done <= 1'b0;
      end else if (clear) begin
         r_ocnt       <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_oacc & w_ocnt_last;
         if (w_oacc) begin
            r_ocnt <= w_ocnt_last ? '0 : r_ocnt + OCNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool.sv
`default_nettype none
// tb_relu_maxpool: directed frames with hand-computed pooled bytes, checked by a
// scoreboard queue popped whenever the DUT hands over an output.
module tb_relu_maxpool;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic [23:0] in_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready = 1'b1;
   logic        frame_done;

   always #5 clk = ~clk;

   relu_maxpool dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .frame_done (frame_done)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       last;
   } exp_t;

   int          checks = 0;
   int          errors = 0;
   exp_t        sbq[$];
   logic        fd_pending = 1'b0;
   logic [23:0] img [64];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: pop expected bytes on every handshake, police frame_done timing.
   always @(negedge clk) begin
      if (!reset) begin
         fd_pending = 1'b0;
      end else begin
         if (fd_pending) begin
            chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
            fd_pending = 1'b0;
         end else if (frame_done) begin
            chk("frame_done_spurious", {31'd0, frame_done}, 32'd0);
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chk("unexpected_output", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("out_data", {24'd0, out_data}, {24'd0, e.d});
               if (e.last) fd_pending = 1'b1;
            end
         end
      end
   end

   task automatic push(input logic [7:0] d, input logic last);
      exp_t e;
      e.d    = d;
      e.last = last;
      sbq.push_back(e);
   endtask

   task automatic push_distinct();
      for (int k = 0; k < 16; k++) push(8'(k + 1), k == 15);
   endtask

   function automatic int pix(input int b, input int sr, input int sc);
      return (2 * (b / 4) + sr) * 8 + 2 * (b % 4) + sc;
   endfunction

   task automatic fill(input logic [23:0] v);
      for (int i = 0; i < 64; i++) img[i] = v;
   endtask

   task automatic set_blk(input int b, input logic [23:0] v);
      for (int s = 0; s < 4; s++) img[pix(b, s / 2, s % 2)] = v;
   endtask

   task automatic set_distinct();
      for (int b = 0; b < 16; b++) set_blk(b, 24'((b + 1) << 8));
   endtask

   task automatic send(input logic [23:0] d);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("in_accept_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_img(input int n);
      for (int i = 0; i < n; i++) send(img[i]);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sbq.size() != 0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      chk("drain", sbq.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] hold;
      int         t;
      int         k;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
      chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
      chk("rst_out_data",   {24'd0, out_data},   32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Uniform 0x100 -> 0x01 everywhere
      fill(24'h000100);
      for (int i = 0; i < 16; i++) push(8'h01, i == 15);
      send_img(64);
      drain();

      // Negative samples clamp to zero
      fill(24'hFFFF00);
      for (int i = 0; i < 16; i++) push(8'h00, i == 15);
      send_img(64);
      drain();

      // Winner moved through each slot of block 0
      for (int p = 0; p < 4; p++) begin
         fill(24'h0);
         k = 1;
         for (int s = 0; s < 4; s++) begin
            if (s == p) begin
               img[pix(0, s / 2, s % 2)] = 24'h000400;
            end else begin
               img[pix(0, s / 2, s % 2)] = 24'(k * 256);
               k++;
            end
         end
         push(8'h04, 1'b0);
         for (int i = 1; i < 16; i++) push(8'h00, i == 15);
         send_img(64);
         drain();
      end

      // Saturation, exact full-scale, underflow, negatives beside a positive
      fill(24'h0);
      set_blk(0, 24'h7FFFFF);
      set_blk(1, 24'h00FF00);
      set_blk(2, 24'h0000FF);
      set_blk(3, 24'h012345);
      set_blk(4, 24'hFFFFFF);
      img[pix(4, 1, 0)] = 24'h000500;
      push(8'hFF, 1'b0);
      push(8'hFF, 1'b0);
      push(8'h00, 1'b0);
      push(8'hFF, 1'b0);
      push(8'h05, 1'b0);
      for (int i = 5; i < 16; i++) push(8'h00, i == 15);
      send_img(64);
      drain();

      // Back-pressure on the first output for 5 cycles
      set_distinct();
      push_distinct();
      fork
         send_img(64);
         begin
            t = 0;
            while (!out_valid && t < 500) begin
               @(posedge clk);
               #1;
               t++;
            end
            out_ready = 1'b0;
            chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
            hold = out_data;
            repeat (5) begin
               @(negedge clk);
               chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
               chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
               chk("bp_out_data",  {24'd0, out_data},  {24'd0, hold});
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Asynchronous reset in row 3 while an output is pending
      fill(24'h000300);
      for (int i = 0; i < 4; i++) push(8'h03, 1'b0);
      send_img(26);
      chk("rst_mid_pre_valid", {31'd0, out_valid}, 32'd1);
      reset = 1'b0;
      #1;
      chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_out_data",  {24'd0, out_data},  32'd0);
      chk("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_mid_queue",     sbq.size(),         0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      set_distinct();
      push_distinct();
      send_img(64);
      drain();

      // Synchronous clear in row 3, colliding sample must be dropped
      fill(24'h000300);
      for (int i = 0; i < 5; i++) push(8'h03, 1'b0);
      send_img(26);
      chk("clr_pre_valid", {31'd0, out_valid}, 32'd1);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 24'h00FFFF;
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
      chk("clr_queue",     sbq.size(),         0);
      set_distinct();
      push_distinct();
      send_img(64);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
